// File: rtl/source_data_sequencer_if.sv
// Source-word and lane-beat handshake bundle for source_data_sequencer.
// The master modport is the sequencer: it consumes source words and drives lane beats.
interface source_data_sequencer_if;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    modport master (
        input  s_data,
        input  s_valid,
        input  m_ready,
        output s_ready,
        output m_data,
        output m_valid,
        output m_last
    );

    modport slave (
        output s_data,
        output s_valid,
        output m_ready,
        input  s_ready,
        input  m_data,
        input  m_valid,
        input  m_last
    );
endinterface

// File: rtl/source_data_sequencer.sv
// Serialises a programmed run of 16-bit source words onto a 1/2/4/8/16-bit lane,
// high byte first with the least-significant group of each byte leading.
module source_data_sequencer #(
    parameter int LEN_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       width_sel,
    input  logic [LEN_W-1:0] word_cnt,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    source_data_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_width;
    logic [LEN_W-1:0] r_words_left;
    logic [15:0]      r_word;
    logic [3:0]       r_beat;
    logic             r_busy;
    logic             r_done;

    logic             w_start_ok;
    logic             w_s_ready;
    logic             w_s_fire;
    logic             w_m_valid;
    logic             w_m_fire;
    logic             w_last_beat;
    logic             w_more_words;
    logic             w_done_next;
    logic             w_hi;
    logic [3:0]       w_beats_m1;
    logic [3:0]       w_bpb_m1;
    logic [3:0]       w_group;
    logic [3:0]       w_offset;
    logic [15:0]      w_mask;
    logic [15:0]      w_shifted;

    // Width code is normalised to 0..4 when latched, so 4 always means a 16-bit lane.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_beats_m1 = 4'd0;
        w_bpb_m1   = 4'd0;
        w_mask     = 16'hFFFF;
        case (r_width)
            3'd0: begin w_beats_m1 = 4'd15; w_bpb_m1 = 4'd7; w_mask = 16'h0001; end
            3'd1: begin w_beats_m1 = 4'd7;  w_bpb_m1 = 4'd3; w_mask = 16'h0003; end
            3'd2: begin w_beats_m1 = 4'd3;  w_bpb_m1 = 4'd1; w_mask = 16'h000F; end
            3'd3: begin w_beats_m1 = 4'd1;  w_bpb_m1 = 4'd0; w_mask = 16'h00FF; end
            default: begin w_beats_m1 = 4'd0; w_bpb_m1 = 4'd0; w_mask = 16'hFFFF; end
        endcase
    end

    // Beats [0, bpb) come from the high byte; the group index within a byte counts up from bit 0.
    assign w_hi      = (r_beat <= w_bpb_m1);
    assign w_group   = r_beat & w_bpb_m1;
    assign w_offset  = (r_width == 3'd4) ? 4'd0
                     : ((w_hi ? 4'd8 : 4'd0) + (w_group << r_width));
    assign w_shifted = r_word >> w_offset;

    assign w_m_valid    = (r_state == ST_SHIFT);
    assign w_last_beat  = (r_beat == w_beats_m1);
    assign w_more_words = (r_words_left != '0);
    assign w_m_fire     = w_m_valid & bus.m_ready;
    assign w_s_fire     = w_s_ready & bus.s_valid;
    assign w_start_ok   = (r_state == ST_IDLE) & start & ~abort;

    // s_ready is held low under abort so no source word is consumed and then thrown away.
    always_comb begin
        w_next_state = r_state;
        w_s_ready    = 1'b0;
        w_done_next  = 1'b0;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (word_cnt != '0) w_next_state = ST_FETCH;
                        else                w_done_next  = 1'b1;
                    end
                end
                ST_FETCH: begin
                    w_s_ready = 1'b1;
                    if (bus.s_valid) w_next_state = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_last_beat) begin
                        if (w_more_words) begin
                            w_s_ready = bus.m_ready;
                            if (bus.m_ready)
                                w_next_state = bus.s_valid ? ST_SHIFT : ST_FETCH;
                        end else if (bus.m_ready) begin
                            w_next_state = ST_IDLE;
                            w_done_next  = 1'b1;
                        end
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_width      <= 3'd0;
            r_words_left <= '0;
            r_word       <= 16'h0000;
            r_beat       <= 4'd0;
        end else begin
            r_busy <= (w_next_state != ST_IDLE);
            r_done <= w_done_next;
            if (w_start_ok && (word_cnt != '0)) begin
                r_width      <= (width_sel > 3'd3) ? 3'd4 : width_sel;
                r_words_left <= word_cnt;
            end
            if (w_s_fire) begin
                r_word       <= bus.s_data;
                r_beat       <= 4'd0;
                r_words_left <= r_words_left - LEN_W'(1);
            end else if (w_m_fire && !abort) begin
                r_beat <= w_last_beat ? 4'd0 : (r_beat + 4'd1);
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = w_m_valid;
    assign bus.m_data  = w_m_valid ? (w_shifted & w_mask) : 16'h0000;
    assign bus.m_last  = w_m_valid & w_last_beat & ~w_more_words;

endmodule

// File: tb/tb_source_data_sequencer.sv
// Scoreboard bench for source_data_sequencer: expected beats are queued with each
// source word and compared as the lane hands beats over.
module tb_source_data_sequencer;

    localparam int LEN_W = 12;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } beat_t;

    localparam logic [15:0] W4_EXP    [4]  = '{16'h2, 16'h1, 16'h4, 16'h3};
    localparam logic [15:0] W1_EXP    [16] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1,
                                               16'h1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    localparam logic [15:0] W2_EXP    [8]  = '{16'h2, 16'h0, 16'h1, 16'h0, 16'h0, 16'h1, 16'h3, 16'h0};
    localparam logic [15:0] ABORT_EXP [8]  = '{16'h3, 16'h2, 16'h2, 16'h2, 16'h1, 16'h3, 16'h0, 16'h3};

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [2:0]       width_sel;
    logic [LEN_W-1:0] word_cnt;
    logic             abort;
    logic             busy;
    logic             done;

    source_data_sequencer_if bus_if ();

    source_data_sequencer #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .width_sel (width_sel),
        .word_cnt  (word_cnt),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .bus       (bus_if)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_beat_cyc = 0;
    int          xfer_beats = 0;
    int          done_cnt = 0;
    int          busy_cycles = 0;
    logic        last_pending = 1'b0;
    logic        stall_mode = 1'b0;
    logic        src_taken = 1'b0;
    logic [15:0] cur_mask = 16'hFFFF;
    logic [15:0] src_q [$];
    beat_t       exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lane_mask(input logic [2:0] code);
        case (code)
            3'd0:    return 16'h0001;
            3'd1:    return 16'h0003;
            3'd2:    return 16'h000F;
            3'd3:    return 16'h00FF;
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic push_exp(input logic [15:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic begin_xfer(input logic [2:0] code, input logic [LEN_W-1:0] cnt);
        cur_mask     = lane_mask(code);
        xfer_beats   = 0;
        last_pending = 1'b0;
        width_sel    = code;
        word_cnt     = cnt;
        start        = 1'b1;
        step();
        start        = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < max_cycles && done_cnt == d0; i++) step();
        check({tag, "_done_seen"}, done_cnt - d0, 1);
        step();
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    task automatic wait_beats(input int n, input int max_cycles);
        for (int i = 0; i < max_cycles && xfer_beats < n; i++) step();
        if (xfer_beats < n) check("wait_beats_timeout", xfer_beats, n);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Source and lane-sink driver: presents queued words, toggles m_ready in stall mode.
    initial begin
        bus_if.s_valid = 1'b0;
        bus_if.s_data  = 16'h0000;
        bus_if.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (src_taken) begin
                if (src_q.size() != 0) void'(src_q.pop_front());
                src_taken = 1'b0;
            end
            bus_if.s_valid = (src_q.size() != 0);
            bus_if.s_data  = (src_q.size() != 0) ? src_q[0] : 16'h0000;
            bus_if.m_ready = stall_mode ? ~bus_if.m_ready : 1'b1;
        end
    end

    // Monitor on the falling edge, well away from the active edge.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (busy) busy_cycles++;
                if (bus_if.s_valid && bus_if.s_ready) src_taken = 1'b1;
                if (bus_if.m_valid && !bus_if.m_ready && exp_q.size() != 0) begin
                    check("stall_data", bus_if.m_data, exp_q[0].data);
                    check("stall_last", bus_if.m_last, exp_q[0].last);
                end
                if (bus_if.m_valid && bus_if.m_ready) begin
                    if (!stall_mode && xfer_beats != 0) check("beat_gap", cyc - last_beat_cyc, 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", bus_if.m_data, 32'hDEAD_0000);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", bus_if.m_data, e.data);
                        check("beat_last", bus_if.m_last, e.last);
                    end
                    check("upper_zero", bus_if.m_data & ~cur_mask, 0);
                    last_beat_cyc = cyc;
                    xfer_beats++;
                    if (bus_if.m_last) last_pending = 1'b1;
                end
                if (done) begin
                    done_cnt++;
                    if (last_pending) check("done_latency", cyc - last_beat_cyc, 1);
                    last_pending = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

    initial begin
        int d0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        width_sel = 3'd0;
        word_cnt  = '0;
        step();
        step();
        check("rst_busy",    busy, 0);
        check("rst_done",    done, 0);
        check("rst_m_valid", bus_if.m_valid, 0);
        check("rst_s_ready", bus_if.s_ready, 0);
        check("rst_m_data",  bus_if.m_data, 0);
        check("rst_m_last",  bus_if.m_last, 0);
        rst_n = 1'b1;
        step();

        // W=4 single word
        for (int i = 0; i < 4; i++) push_exp(W4_EXP[i], i == 3);
        src_q.push_back(16'h1234);
        begin_xfer(3'd2, 1);
        wait_done("w4", 50);
        check("w4_beats", xfer_beats, 4);

        // W=1 single word
        for (int i = 0; i < 16; i++) push_exp(W1_EXP[i], i == 15);
        src_q.push_back(16'h8001);
        begin_xfer(3'd0, 1);
        wait_done("w1", 80);
        check("w1_beats", xfer_beats, 16);

        // W=2 with m_ready low every other cycle
        stall_mode = 1'b1;
        for (int i = 0; i < 8; i++) push_exp(W2_EXP[i], i == 7);
        src_q.push_back(16'h1234);
        begin_xfer(3'd1, 1);
        wait_done("w2_stall", 100);
        stall_mode = 1'b0;
        step();

        // W=16 streaming, three words, no bubbles
        push_exp(16'hAAAA, 1'b0);
        push_exp(16'h5555, 1'b0);
        push_exp(16'hF00F, 1'b1);
        src_q.push_back(16'hAAAA);
        src_q.push_back(16'h5555);
        src_q.push_back(16'hF00F);
        busy_cycles = 0;
        begin_xfer(3'd4, 3);
        wait_done("w16", 50);
        step();
        check("w16_busy_cycles", busy_cycles, 4);
        check("w16_beats", xfer_beats, 3);

        // Abort during the third beat of eight at W=2
        for (int i = 0; i < 8; i++) push_exp(ABORT_EXP[i], i == 7);
        src_q.push_back(16'hABCD);
        begin_xfer(3'd1, 1);
        wait_beats(2, 50);
        d0    = done_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_m_valid", bus_if.m_valid, 0);
        check("abort_busy",    busy, 0);
        check("abort_s_ready", bus_if.s_ready, 0);
        check("abort_m_data",  bus_if.m_data, 0);
        exp_q.delete();
        repeat (3) step();
        check("abort_no_done", done_cnt, d0);

        // Normal transfer after abort
        push_exp(16'h0012, 1'b0);
        push_exp(16'h0034, 1'b1);
        src_q.push_back(16'h1234);
        begin_xfer(3'd3, 1);
        wait_done("post_abort", 50);

        // word_cnt = 0 completes at once with no beats
        d0 = done_cnt;
        begin_xfer(3'd2, 0);
        check("zero_done_pulse", done, 1);
        check("zero_busy",       busy, 0);
        step();
        check("zero_done_single", done, 0);
        check("zero_done_count",  done_cnt - d0, 1);
        check("zero_no_beats",    xfer_beats, 0);

        // start and abort together in IDLE: abort wins
        d0        = done_cnt;
        width_sel = 3'd2;
        word_cnt  = 1;
        start     = 1'b1;
        abort     = 1'b1;
        step();
        start     = 1'b0;
        abort     = 1'b0;
        check("start_abort_busy",    busy, 0);
        check("start_abort_s_ready", bus_if.s_ready, 0);
        step();
        check("start_abort_no_done", done_cnt, d0);

        // start while busy is ignored; config changes mid-transfer have no effect
        push_exp(16'h0012, 1'b0);
        push_exp(16'h0034, 1'b0);
        push_exp(16'h00BE, 1'b0);
        push_exp(16'h00EF, 1'b1);
        begin_xfer(3'd3, 2);
        step();
        d0        = done_cnt;
        width_sel = 3'd0;
        word_cnt  = 5;
        start     = 1'b1;
        step();
        start     = 1'b0;
        check("busy_start_busy", busy, 1);
        src_q.push_back(16'h1234);
        src_q.push_back(16'hBEEF);
        wait_done("busy_start", 80);
        repeat (3) step();
        check("busy_start_one_done", done_cnt - d0, 1);
        check("busy_start_beats", xfer_beats, 4);

        // Reset asserted mid-transfer clears all outputs without a clock edge
        for (int i = 0; i < 32; i++) push_exp(16'h0001, i == 31);
        src_q.push_back(16'hFFFF);
        src_q.push_back(16'hFFFF);
        begin_xfer(3'd0, 2);
        wait_beats(5, 50);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy",    busy, 0);
        check("midrst_done",    done, 0);
        check("midrst_m_valid", bus_if.m_valid, 0);
        check("midrst_s_ready", bus_if.s_ready, 0);
        check("midrst_m_data",  bus_if.m_data, 0);
        check("midrst_m_last",  bus_if.m_last, 0);
        exp_q.delete();
        src_q.delete();
        src_taken = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Clean transfer after reset
        push_exp(16'h1357, 1'b1);
        src_q.push_back(16'h1357);
        begin_xfer(3'd7, 1);
        wait_done("post_reset", 50);
        check("post_reset_beats", xfer_beats, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
